pd_tx_retry_ctrl: RTL
=====================

Name: pd_tx_retry_ctrl

Overview:
- Protocol-layer transmit sequencer that sits above the PHY tx/rx control block.
- Takes one message-send request from the policy engine, then:
  - issues PL2PHY_Tx_Packet_en to the PHY;
  - switches the PHY to receive;
  - waits for a GoodCRC within a CRC-receive timeout;
  - retries up to RETRY_MAX times.
- Owns the 3-bit MessageIDCounter and reports one final status per request.

Parameters:
- RETRY_MAX, 2: retransmissions after the first attempt (nRetryCount); total attempts = RETRY_MAX+1.
- CRC_TIMER_MAX, 16'd46800: clk cycles to wait for GoodCRC (tCRCReceive); timer is 16 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- msg_tx_req  in  1  single-cycle request from policy engine; ignored unless msg_tx_busy=0
- msg_tx_sop_type  in  3  SOP type, sampled with msg_tx_req
- msg_tx_abort  in  1  hard-reset abort, level
- msg_id_clr  in  1  soft-reset clear of MessageIDCounter
- msg_tx_busy  out  1  high from the cycle after an accepted request until the DONE cycle inclusive
- msg_tx_done  out  1  one-cycle completion pulse
- msg_tx_status  out  2  0 success, 1 discarded, 2 no GoodCRC, 3 aborted; held until the next accepted request
- tx_msg_id  out  3  current MessageIDCounter
- retry_cnt  out  2  retransmissions done for the current request
- PL2PHY_Tx_Packet_en  out  1  one-cycle transmit start pulse
- PL2PHY_Tx_Packet_type  out  3  latched SOP type, stable from TX_REQ until DONE
- PHY2PL_Tx_Packet_done  in  1  PHY transmit finished
- PHY2PL_Tx_Packet_result  in  1  1 = CC not idle, packet not sent
- PL2PHY_Rx_Packet_select  out  1  one-cycle pulse to switch the PHY to receive
- PHY2PL_Rx_Packet_done  in  1  PHY receive finished
- PHY2PL_Rx_Packet_result  in  2  0 ok, 1 crc error, 2 payload error, 3 timeout
- rx_msg_is_goodcrc  in  1  decoder flag, valid with PHY2PL_Rx_Packet_done
- rx_msg_id  in  3  MessageID of the received message, valid with PHY2PL_Rx_Packet_done

Behaviour:
- Reset values: all outputs 0; state IDLE; crc timer 0.
- States: IDLE, TX_REQ, TX_WAIT, RX_ARM, WAIT_CRC, RX_REARM, RETRY_CHK, DONE.
- IDLE:
  - On msg_tx_req: latch msg_tx_sop_type, clear retry_cnt -> TX_REQ. Latency from req to Tx_Packet_en is 1 cycle.
- TX_REQ:
  - PL2PHY_Tx_Packet_en=1 for exactly this cycle -> TX_WAIT.
- TX_WAIT:
  - Tx_done with result=1 -> DONE, status 1; no retry, no id increment.
  - Tx_done with result=0 -> RX_ARM.
- RX_ARM:
  - Rx_Packet_select=1 for one cycle; crc timer cleared to 0 -> WAIT_CRC.
- WAIT_CRC: timer increments by 1 each cycle.
  - Rx_done, result 0, goodcrc=1 and rx_msg_id==tx_msg_id -> DONE, status 0, tx_msg_id+1 (mod 8).
  - Rx_done, result 0, goodcrc=0 -> DONE, status 1 (incoming message wins), no id increment.
  - Rx_done, result 0, goodcrc=1 with mismatched id -> treated as an error, same as the next case.
  - Rx_done with result!=0 -> RX_REARM. The timer is not cleared and keeps counting.
  - timer==CRC_TIMER_MAX with no Rx_done -> RETRY_CHK.
  - Rx_done and expiry in the same cycle: Rx_done takes priority.
- RX_REARM:
  - Rx_Packet_select pulse; timer continues -> WAIT_CRC.
  - If the timer hits CRC_TIMER_MAX in this cycle -> RETRY_CHK.
- RETRY_CHK:
  - retry_cnt<RETRY_MAX -> retry_cnt+1 -> TX_REQ. The PHY's own inter-frame gap handles spacing.
  - Otherwise -> DONE, status 2, tx_msg_id+1.
- DONE:
  - msg_tx_done=1 for one cycle -> IDLE.
  - A new msg_tx_req in the DONE cycle is ignored.
- msg_tx_abort:
  - In any state except IDLE/DONE -> DONE next cycle with status 3; no id increment; timer and retry_cnt are cleared.
  - In IDLE it is ignored and suppresses msg_tx_req in the same cycle.
- msg_id_clr:
  - Sets tx_msg_id=0 in any cycle, with priority over a simultaneous increment.
- PHY done inputs arriving in states that do not expect them are ignored.
- rst_n assertion mid-operation: immediate return to IDLE with all outputs 0; no done pulse is generated.

Test Plan (CRC_TIMER_MAX=100, RETRY_MAX=2 unless noted):
- Success path: req type=3'd0, Tx_done result 0, then Rx_done result 0, goodcrc=1, id=0 at timer 20 -> one Tx_en pulse, one Rx_select pulse, done with status 0, tx_msg_id=1, retry_cnt=0.
- No GoodCRC: Tx_done result 0 every attempt, no Rx_done -> 3 Tx_en pulses each ≥101 cycles apart, then done with status 2, retry_cnt=2, tx_msg_id incremented.
- CC busy: Tx_done result 1 -> done with status 1 one cycle later; no Rx_select pulse; tx_msg_id unchanged.
- CRC error then GoodCRC: Rx_done result 1 at timer 30 -> Rx_select re-pulses and the timer is not reset; GoodCRC at timer 60 -> status 0. Separately, GoodCRC arriving in the cycle where timer==100 -> status 0, with no retry.
- Interrupting message and mismatched id:
  - Rx_done result 0, goodcrc=0 -> status 1, tx_msg_id unchanged.
  - GoodCRC with id mismatch -> re-arm, then status 2 after retries.
- Abort and clear:
  - msg_tx_abort in WAIT_CRC -> done with status 3 next cycle.
  - msg_id_clr together with a successful GoodCRC -> tx_msg_id=0.
  - rst_n pulse during TX_WAIT -> busy=0 and no done pulse.

Source files
------------

// File: rtl/pd_tx_retry_ctrl_if.sv
// Policy-engine and PHY signal bundle for the protocol-layer tx sequencer.
// slave is the sequencer side, master the policy engine / PHY side.
interface pd_tx_retry_ctrl_if;
  logic       msg_tx_req;
  logic [2:0] msg_tx_sop_type;
  logic       msg_tx_abort;
  logic       msg_id_clr;
  logic       msg_tx_busy;
  logic       msg_tx_done;
  logic [1:0] msg_tx_status;
  logic [2:0] tx_msg_id;
  logic [1:0] retry_cnt;
  logic       PL2PHY_Tx_Packet_en;
  logic [2:0] PL2PHY_Tx_Packet_type;
  logic       PHY2PL_Tx_Packet_done;
  logic       PHY2PL_Tx_Packet_result;
  logic       PL2PHY_Rx_Packet_select;
  logic       PHY2PL_Rx_Packet_done;
  logic [1:0] PHY2PL_Rx_Packet_result;
  logic       rx_msg_is_goodcrc;
  logic [2:0] rx_msg_id;

  modport slave (
    input  msg_tx_req,
    input  msg_tx_sop_type,
    input  msg_tx_abort,
    input  msg_id_clr,
    output msg_tx_busy,
    output msg_tx_done,
    output msg_tx_status,
    output tx_msg_id,
    output retry_cnt,
    output PL2PHY_Tx_Packet_en,
    output PL2PHY_Tx_Packet_type,
    input  PHY2PL_Tx_Packet_done,
    input  PHY2PL_Tx_Packet_result,
    output PL2PHY_Rx_Packet_select,
    input  PHY2PL_Rx_Packet_done,
    input  PHY2PL_Rx_Packet_result,
    input  rx_msg_is_goodcrc,
    input  rx_msg_id
  );

  modport master (
    output msg_tx_req,
    output msg_tx_sop_type,
    output msg_tx_abort,
    output msg_id_clr,
    input  msg_tx_busy,
    input  msg_tx_done,
    input  msg_tx_status,
    input  tx_msg_id,
    input  retry_cnt,
    input  PL2PHY_Tx_Packet_en,
    input  PL2PHY_Tx_Packet_type,
    output PHY2PL_Tx_Packet_done,
    output PHY2PL_Tx_Packet_result,
    input  PL2PHY_Rx_Packet_select,
    output PHY2PL_Rx_Packet_done,
    output PHY2PL_Rx_Packet_result,
    output rx_msg_is_goodcrc,
    output rx_msg_id
  );
endinterface

// File: rtl/pd_tx_retry_ctrl.sv
// Protocol-layer transmit sequencer: send, await GoodCRC, retry,
// and own the MessageIDCounter; one final status per request.
module pd_tx_retry_ctrl #(
  parameter int unsigned RETRY_MAX     = 2,
  parameter logic [15:0] CRC_TIMER_MAX = 16'd46800
) (
  input logic               clk,
  input logic               rst_n,
  pd_tx_retry_ctrl_if.slave bus
);

  localparam logic [1:0] RMAX = RETRY_MAX[1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_REQ,
    S_TX_WAIT,
    S_RX_ARM,
    S_WAIT_CRC,
    S_RX_REARM,
    S_RETRY_CHK,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] tmr;
  logic [1:0]  rcnt;
  logic [1:0]  status_q;
  logic [2:0]  msg_id;
  logic [2:0]  typ_q;

  logic        accept;
  logic        fin;
  logic [1:0]  fin_st;
  logic        id_inc;
  logic        r_inc;
  logic        r_clr;
  logic        t_clr;
  logic        t_run;

  logic        in_flight;
  logic        expired;
  logic        rx_ok;
  logic        crc_ok;

  assign in_flight = (state != S_IDLE) && (state != S_DONE);
  // >= rather than == so an error landing on the last tick still expires
  assign expired   = tmr >= CRC_TIMER_MAX;
  assign rx_ok     = bus.PHY2PL_Rx_Packet_result == 2'd0;
  assign crc_ok    = bus.rx_msg_is_goodcrc &&
                     (bus.rx_msg_id == msg_id);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fin       = 1'b0;
    fin_st    = 2'd0;
    id_inc    = 1'b0;
    r_inc     = 1'b0;
    r_clr     = 1'b0;
    t_clr     = 1'b0;
    t_run     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.msg_tx_req && !bus.msg_tx_abort) begin
          accept    = 1'b1;
          state_nxt = S_TX_REQ;
        end
      end
      S_TX_REQ: state_nxt = S_TX_WAIT;
      S_TX_WAIT: begin
        if (bus.PHY2PL_Tx_Packet_done) begin
          if (bus.PHY2PL_Tx_Packet_result) begin
            fin       = 1'b1;
            fin_st    = 2'd1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RX_ARM;
          end
        end
      end
      S_RX_ARM: begin
        t_clr     = 1'b1;
        state_nxt = S_WAIT_CRC;
      end
      S_WAIT_CRC: begin
        t_run = 1'b1;
        if (bus.PHY2PL_Rx_Packet_done) begin
          if (rx_ok && !bus.rx_msg_is_goodcrc) begin
            fin       = 1'b1;
            fin_st    = 2'd1;
            state_nxt = S_DONE;
          end else if (rx_ok && crc_ok) begin
            fin       = 1'b1;
            fin_st    = 2'd0;
            id_inc    = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RX_REARM;
          end
        end else if (expired) begin
          state_nxt = S_RETRY_CHK;
        end
      end
      S_RX_REARM: begin
        t_run     = 1'b1;
        state_nxt = expired ? S_RETRY_CHK : S_WAIT_CRC;
      end
      S_RETRY_CHK: begin
        if (rcnt < RMAX) begin
          r_inc     = 1'b1;
          state_nxt = S_TX_REQ;
        end else begin
          fin       = 1'b1;
          fin_st    = 2'd2;
          id_inc    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: state_nxt = S_IDLE;
    endcase

    // hard-reset abort overrides whatever the state decided
    if (bus.msg_tx_abort && in_flight) begin
      state_nxt = S_DONE;
      fin       = 1'b1;
      fin_st    = 2'd3;
      id_inc    = 1'b0;
      r_inc     = 1'b0;
      r_clr     = 1'b1;
      t_clr     = 1'b1;
      t_run     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr      <= '0;
      rcnt     <= '0;
      status_q <= '0;
      msg_id   <= '0;
      typ_q    <= '0;
    end else begin
      if (accept) begin
        typ_q    <= bus.msg_tx_sop_type;
        rcnt     <= '0;
        status_q <= '0;
      end else if (r_clr) begin
        rcnt <= '0;
      end else if (r_inc) begin
        rcnt <= rcnt + 2'd1;
      end
      if (t_clr)      tmr <= '0;
      else if (t_run) tmr <= tmr + 16'd1;
      if (fin) status_q <= fin_st;
      if (bus.msg_id_clr) msg_id <= '0;
      else if (id_inc)    msg_id <= msg_id + 3'd1;
    end
  end

  assign bus.msg_tx_busy             = state != S_IDLE;
  assign bus.msg_tx_done             = state == S_DONE;
  assign bus.msg_tx_status           = status_q;
  assign bus.tx_msg_id               = msg_id;
  assign bus.retry_cnt               = rcnt;
  assign bus.PL2PHY_Tx_Packet_en     = state == S_TX_REQ;
  assign bus.PL2PHY_Tx_Packet_type   = typ_q;
  assign bus.PL2PHY_Rx_Packet_select = (state == S_RX_ARM) ||
                                       (state == S_RX_REARM);

endmodule
